// File: rtl/datapath_stack.sv
// datapath_stack: packet-CPU datapath with A/X/PC, scratch and constant tables,
// instruction memory, a registered ALU and a call/return stack with sticky error flags.
module datapath_stack #(
  parameter int DATA_WIDTH      = 32,
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int INST_WIDTH      = 8,
  parameter int UTIL_ADDR_WIDTH = 4,
  parameter int JMP_WIDTH       = 8,
  parameter int STACK_DEPTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inst_rd_en,
  output logic [INST_WIDTH-1:0]                instr,
  input  logic [2:0]                           A_sel,
  input  logic [2:0]                           X_sel,
  input  logic                                 A_en,
  input  logic                                 X_en,
  input  logic [2:0]                           PC_sel,
  input  logic                                 PC_en,
  input  logic                                 B_sel,
  input  logic [3:0]                           ALU_sel,
  input  logic                                 ALU_en,
  output logic                                 eq,
  output logic                                 gt,
  output logic                                 ge,
  output logic                                 set,
  input  logic [DATA_WIDTH-1:0]                din_TDATA,
  input  logic                                 din_TLAST,
  output logic [DATA_WIDTH-1:0]                dout_TDATA,
  output logic                                 dout_TLAST,
  input  logic                                 last_en,
  input  logic                                 last_out,
  output logic                                 last,
  input  logic [UTIL_ADDR_WIDTH-1:0]           utility_addr,
  input  logic                                 regfile_sel,
  input  logic                                 regfile_wr_en,
  input  logic                                 imm_sel_en,
  input  logic                                 jmp_off_sel_en,
  input  logic                                 imm_wr_en,
  input  logic [UTIL_ADDR_WIDTH-1:0]           imm_wr_addr,
  input  logic [DATA_WIDTH-1:0]                imm_wr_data,
  input  logic                                 jmp_off_wr_en,
  input  logic [UTIL_ADDR_WIDTH-1:0]           jmp_off_wr_addr,
  input  logic [JMP_WIDTH-1:0]                 jmp_off_wr_data,
  input  logic                                 inst_mem_wr_en,
  input  logic [CODE_ADDR_WIDTH-1:0]           inst_mem_wr_addr,
  input  logic [INST_WIDTH-1:0]                inst_mem_wr_data,
  input  logic [CODE_ADDR_WIDTH-1:0]           jmp_correction,
  input  logic                                 branch_mispredict,
  output logic                                 stack_ovf,
  output logic                                 stack_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level
);
  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam int SW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int EW = JMP_WIDTH > CODE_ADDR_WIDTH ? JMP_WIDTH : CODE_ADDR_WIDTH;
  localparam int CW = CODE_ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] scratch [2**UTIL_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] imm_tab [2**UTIL_ADDR_WIDTH];
  logic [JMP_WIDTH-1:0]  jmp_tab [2**UTIL_ADDR_WIDTH];
  logic [INST_WIDTH-1:0] inst_mem [2**CODE_ADDR_WIDTH];
  logic [CW-1:0]         stk_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] a_q, a_d, x_q, x_d, alu_q, alu_d, alu_r, b, imm;
  logic [CW-1:0] pc_q, pc_d, jmp_off, jmp_tgt, ret_addr;
  logic signed [EW-1:0] jmp_ext;
  logic [UTIL_ADDR_WIDTH-1:0] imm_sel_q, imm_sel_d, jmp_sel_q, jmp_sel_d;
  logic [LW-1:0] sp_q, sp_d;
  logic [INST_WIDTH-1:0] instr_q, instr_d;
  logic last_q, last_d, ovf_q, ovf_d, unf_q, unf_d, push, full, empty;
  always_comb begin
    imm      = imm_tab[imm_sel_q];
    jmp_ext  = EW'($signed(jmp_tab[jmp_sel_q]));
    jmp_off  = jmp_ext[CW-1:0];
    b        = B_sel ? imm : x_q;
    alu_r    = ALU_sel == 4'd0 ? a_q + b :
               ALU_sel == 4'd1 ? a_q - b :
               ALU_sel == 4'd2 ? a_q & b :
               ALU_sel == 4'd3 ? a_q | b :
               ALU_sel == 4'd4 ? a_q ^ b :
               ALU_sel == 4'd5 ? a_q << b[SW-1:0] :
               ALU_sel == 4'd6 ? a_q >> b[SW-1:0] :
               ALU_sel == 4'd7 ? -a_q : '0;
    alu_d    = branch_mispredict ? '0 : ALU_en ? alu_r : alu_q;
    a_d      = !A_en ? a_q :
               A_sel == 3'd0 ? imm :
               A_sel == 3'd1 ? scratch[utility_addr] :
               A_sel == 3'd2 ? alu_q :
               A_sel == 3'd3 ? din_TDATA :
               A_sel == 3'd4 ? x_q : a_q;
    x_d      = !X_en ? x_q :
               X_sel == 3'd0 ? imm :
               X_sel == 3'd1 ? scratch[utility_addr] :
               X_sel == 3'd3 ? din_TDATA :
               X_sel == 3'd4 ? a_q : x_q;
    imm_sel_d = imm_sel_en ? utility_addr : imm_sel_q;
    jmp_sel_d = jmp_off_sel_en ? utility_addr : jmp_sel_q;
    last_d   = last_en ? din_TLAST : last_q;
    instr_d  = inst_rd_en ? inst_mem[pc_q] : instr_q;
    jmp_tgt  = pc_q + jmp_off - jmp_correction;
    ret_addr = pc_q + CW'(1) - jmp_correction;
    full     = sp_q == LW'(STACK_DEPTH);
    empty    = sp_q == '0;
    push     = PC_en && PC_sel == 3'd3 && !full;
    pc_d     = pc_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (PC_en && PC_sel == 3'd1) pc_d = pc_q + CW'(1);
    if (PC_en && (PC_sel == 3'd2 || PC_sel == 3'd3)) pc_d = jmp_tgt;
    if (PC_en && PC_sel == 3'd3) begin
      sp_d  = full ? sp_q : sp_q + LW'(1);
      ovf_d = ovf_q | full;
    end
    if (PC_en && PC_sel == 3'd4) begin
      pc_d  = empty ? '0 : stk_q[IW'(sp_q - LW'(1))];
      sp_d  = empty ? sp_q : sp_q - LW'(1);
      unf_d = unf_q | empty;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      x_q       <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      imm_sel_q <= '0;
      jmp_sel_q <= '0;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      last_q    <= 1'b0;
      instr_q   <= '0;
    end else begin
      a_q       <= a_d;
      x_q       <= x_d;
      alu_q     <= alu_d;
      pc_q      <= pc_d;
      imm_sel_q <= imm_sel_d;
      jmp_sel_q <= jmp_sel_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      last_q    <= last_d;
      instr_q   <= instr_d;
    end
  end
  // storage arrays carry no reset; the stack write is harmless under rst since sp is cleared
  always_ff @(posedge clk) begin
    if (regfile_wr_en) scratch[utility_addr] <= regfile_sel ? x_q : a_q;
    if (imm_wr_en) imm_tab[imm_wr_addr] <= imm_wr_data;
    if (jmp_off_wr_en) jmp_tab[jmp_off_wr_addr] <= jmp_off_wr_data;
    if (inst_mem_wr_en) inst_mem[inst_mem_wr_addr] <= inst_mem_wr_data;
    if (push) stk_q[IW'(sp_q)] <= ret_addr;
  end
  assign eq          = a_q == b;
  assign gt          = a_q > b;
  assign ge          = a_q >= b;
  assign set         = |(a_q & b);
  assign instr       = instr_q;
  assign dout_TDATA  = regfile_sel ? x_q : a_q;
  assign dout_TLAST  = last_out;
  assign last        = last_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
  assign stack_level = sp_q;
endmodule

// File: tb/tb_datapath_stack.sv
// tb_datapath_stack: table-driven ALU/flag vectors plus directed PC, stack, reset and memory sequences.
module tb_datapath_stack;
  logic clk = 1'b0;
  logic rst, inst_rd_en, A_en, X_en, PC_en, B_sel, ALU_en;
  logic [7:0] instr;
  logic [2:0] A_sel, X_sel, PC_sel;
  logic [3:0] ALU_sel;
  logic eq, gt, ge, set;
  logic [31:0] din_TDATA, dout_TDATA, imm_wr_data;
  logic din_TLAST, dout_TLAST, last_en, last_out, last;
  logic [3:0] utility_addr, imm_wr_addr, jmp_off_wr_addr;
  logic regfile_sel, regfile_wr_en, imm_sel_en, jmp_off_sel_en, imm_wr_en, jmp_off_wr_en;
  logic [7:0] jmp_off_wr_data, inst_mem_wr_data;
  logic inst_mem_wr_en, branch_mispredict, stack_ovf, stack_unf;
  logic [9:0] inst_mem_wr_addr, jmp_correction;
  logic [2:0] stack_level;
  logic [7:0] mm [1024];
  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;
  vec_t v [10];

  datapath_stack dut (
    .clk(clk), .rst(rst), .inst_rd_en(inst_rd_en), .instr(instr),
    .A_sel(A_sel), .X_sel(X_sel), .A_en(A_en), .X_en(X_en),
    .PC_sel(PC_sel), .PC_en(PC_en), .B_sel(B_sel), .ALU_sel(ALU_sel), .ALU_en(ALU_en),
    .eq(eq), .gt(gt), .ge(ge), .set(set),
    .din_TDATA(din_TDATA), .din_TLAST(din_TLAST), .dout_TDATA(dout_TDATA), .dout_TLAST(dout_TLAST),
    .last_en(last_en), .last_out(last_out), .last(last),
    .utility_addr(utility_addr), .regfile_sel(regfile_sel), .regfile_wr_en(regfile_wr_en),
    .imm_sel_en(imm_sel_en), .jmp_off_sel_en(jmp_off_sel_en),
    .imm_wr_en(imm_wr_en), .imm_wr_addr(imm_wr_addr), .imm_wr_data(imm_wr_data),
    .jmp_off_wr_en(jmp_off_wr_en), .jmp_off_wr_addr(jmp_off_wr_addr), .jmp_off_wr_data(jmp_off_wr_data),
    .inst_mem_wr_en(inst_mem_wr_en), .inst_mem_wr_addr(inst_mem_wr_addr), .inst_mem_wr_data(inst_mem_wr_data),
    .jmp_correction(jmp_correction), .branch_mispredict(branch_mispredict),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .stack_level(stack_level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int i);
    return 8'(i) + 8'(97 * (i >> 8)) + 8'h5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // PC is observed through the instruction fetched at it one cycle later
  task automatic chk_pc(string n, int p);
    PC_en = 1'b0;
    step();
    chk(n, 32'(instr), 32'(mm[p]));
  endtask

  task automatic get_a(output logic [31:0] r);
    regfile_sel = 1'b0;
    #0 r = dout_TDATA;
  endtask

  task automatic pc_op(logic [2:0] s);
    PC_sel = s;
    PC_en = 1'b1;
    step();
    PC_en = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int exp_pc [5];
    v[0] = '{4'd0, 32'h0000_0005, 32'h0000_0005, 32'h0000_000A, 4'b1011};
    v[1] = '{4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0001};
    v[2] = '{4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0111};
    v[3] = '{4'd3, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 4'b0110};
    v[4] = '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b0111};
    v[5] = '{4'd5, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 4'b0000};
    v[6] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0110};
    v[7] = '{4'd7, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1011};
    v[8] = '{4'd9, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b1011};
    v[9] = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 4'b0111};
    {inst_rd_en, A_en, X_en, PC_en, B_sel, ALU_en, din_TLAST, last_en, last_out} = '0;
    {regfile_sel, regfile_wr_en, imm_sel_en, jmp_off_sel_en, imm_wr_en, jmp_off_wr_en} = '0;
    {inst_mem_wr_en, branch_mispredict} = '0;
    {A_sel, X_sel, PC_sel, ALU_sel, utility_addr, imm_wr_addr, jmp_off_wr_addr} = '0;
    {din_TDATA, imm_wr_data, jmp_off_wr_data, inst_mem_wr_data, inst_mem_wr_addr, jmp_correction} = '0;
    rst = 1'b1;
    inst_mem_wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      inst_mem_wr_addr = 10'(i);
      inst_mem_wr_data = pat(i);
      mm[i] = pat(i);
      step();
    end
    inst_mem_wr_en = 1'b0;
    // reset wins over every enable
    {inst_rd_en, A_en, X_en, PC_en, ALU_en, last_en, din_TLAST, imm_sel_en, jmp_off_sel_en} = '1;
    A_sel = 3'd3; X_sel = 3'd3; PC_sel = 3'd1; din_TDATA = 32'hDEAD_BEEF;
    step();
    chk("rst_a", dout_TDATA, 32'h0);
    regfile_sel = 1'b1;
    #0 chk("rst_x", dout_TDATA, 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_stack", {27'b0, stack_level, stack_ovf, stack_unf}, 32'h0);
    chk("rst_last", 32'(last), 32'h0);
    {A_en, X_en, PC_en, ALU_en, last_en, din_TLAST, imm_sel_en, jmp_off_sel_en, regfile_sel} = '0;
    rst = 1'b0;
    chk_pc("rst_pc", 0);

    foreach (v[k]) begin
      din_TDATA = v[k].a; A_sel = 3'd3; A_en = 1'b1;
      step();
      A_en = 1'b0; din_TDATA = v[k].b; X_sel = 3'd3; X_en = 1'b1;
      step();
      X_en = 1'b0;
      chk($sformatf("flags%0d", k), 32'({eq, gt, ge, set}), 32'(v[k].f));
      ALU_sel = v[k].op; ALU_en = 1'b1;
      step();
      ALU_en = 1'b0; A_sel = 3'd2; A_en = 1'b1;
      step();
      A_en = 1'b0;
      get_a(r);
      chk($sformatf("alu%0d", k), r, v[k].r);
    end

    imm_wr_en = 1'b1; imm_wr_addr = 4'd3; imm_wr_data = 32'h5;
    step();
    imm_wr_en = 1'b0; utility_addr = 4'd3; imm_sel_en = 1'b1;
    step();
    imm_sel_en = 1'b0; A_sel = 3'd0; X_sel = 3'd0; A_en = 1'b1; X_en = 1'b1;
    step();
    A_en = 1'b0; X_en = 1'b0; B_sel = 1'b0; ALU_sel = 4'd0; ALU_en = 1'b1;
    step();
    ALU_en = 1'b0; A_sel = 3'd2; A_en = 1'b1;
    step();
    A_en = 1'b0;
    get_a(r);
    chk("imm_add", r, 32'hA);
    chk("imm_flags", 32'({eq, gt, ge, set}), 32'b0110);
    B_sel = 1'b1;
    #0 chk("imm_flags_bimm", 32'({eq, gt, ge, set}), 32'b0110);
    B_sel = 1'b0; X_sel = 3'd4; X_en = 1'b1;
    step();
    X_en = 1'b0; regfile_sel = 1'b1;
    #0 chk("x_from_a", dout_TDATA, 32'hA);
    regfile_sel = 1'b0; regfile_wr_en = 1'b1; utility_addr = 4'd7;
    step();
    regfile_wr_en = 1'b0; din_TDATA = 32'h0; A_sel = 3'd3; A_en = 1'b1;
    step();
    A_sel = 3'd1;
    step();
    A_en = 1'b0;
    get_a(r);
    chk("scratch_rd", r, 32'hA);

    last_en = 1'b1; din_TLAST = 1'b1;
    step();
    last_en = 1'b0; din_TLAST = 1'b0;
    step();
    chk("last_hold", 32'(last), 32'h1);
    last_out = 1'b1;
    #0 chk("dout_tlast", 32'(dout_TLAST), 32'h1);

    jmp_off_wr_en = 1'b1; jmp_off_wr_addr = 4'd2; jmp_off_wr_data = 8'hFC;
    step();
    jmp_off_wr_addr = 4'd6; jmp_off_wr_data = 8'd10;
    step();
    jmp_off_wr_en = 1'b0; jmp_correction = 10'd1;
    do_rst();
    for (int i = 0; i < 20; i++) pc_op(3'd1);
    utility_addr = 4'd2; jmp_off_sel_en = 1'b1;
    step();
    jmp_off_sel_en = 1'b0;
    pc_op(3'd2);
    chk_pc("jmp_back", 15);
    do_rst();
    pc_op(3'd1);
    pc_op(3'd1);
    jmp_off_sel_en = 1'b1;
    step();
    jmp_off_sel_en = 1'b0;
    pc_op(3'd2);
    chk_pc("jmp_wrap", 10'h3FD);

    do_rst();
    for (int i = 0; i < 3; i++) pc_op(3'd1);
    utility_addr = 4'd6; jmp_off_sel_en = 1'b1;
    step();
    jmp_off_sel_en = 1'b0;
    exp_pc = '{12, 21, 30, 39, 48};
    for (int i = 0; i < 5; i++) begin
      pc_op(3'd3);
      chk($sformatf("call%0d_lvl", i), {29'b0, stack_level}, 32'(i < 4 ? i + 1 : 4));
      chk($sformatf("call%0d_ovf", i), 32'(stack_ovf), 32'(i == 4));
      chk_pc($sformatf("call%0d_pc", i), exp_pc[i]);
    end
    exp_pc = '{30, 21, 12, 3, 0};
    for (int i = 0; i < 5; i++) begin
      pc_op(3'd4);
      chk($sformatf("ret%0d_lvl", i), {29'b0, stack_level}, 32'(i < 4 ? 3 - i : 0));
      chk($sformatf("ret%0d_unf", i), 32'(stack_unf), 32'(i == 4));
      chk_pc($sformatf("ret%0d_pc", i), exp_pc[i]);
    end
    chk("ovf_sticky", 32'(stack_ovf), 32'h1);
    pc_op(3'd1);
    PC_sel = 3'd3; PC_en = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; PC_en = 1'b0;
    chk("rst_call", {27'b0, stack_level, stack_ovf, stack_unf}, 32'h0);

    din_TDATA = 32'd7; A_sel = 3'd3; A_en = 1'b1; X_sel = 3'd3; X_en = 1'b1;
    step();
    din_TDATA = 32'd0; A_en = 1'b0;
    step();
    X_en = 1'b0; ALU_sel = 4'd0; ALU_en = 1'b1;
    step();
    ALU_en = 1'b0; A_sel = 3'd2; A_en = 1'b1;
    step();
    get_a(r);
    chk("alu_capture", r, 32'd7);
    A_en = 1'b0; branch_mispredict = 1'b1;
    step();
    branch_mispredict = 1'b0; A_en = 1'b1;
    step();
    A_en = 1'b0;
    get_a(r);
    chk("mispredict", r, 32'd0);

    chk_pc("pc_zero", 0);
    inst_mem_wr_en = 1'b1; inst_mem_wr_addr = 10'd0; inst_mem_wr_data = 8'hC3;
    step();
    inst_mem_wr_en = 1'b0;
    chk("rdw_old", 32'(instr), 32'(mm[0]));
    mm[0] = 8'hC3;
    step();
    chk("rdw_new", 32'(instr), 32'(mm[0]));
    inst_rd_en = 1'b0; inst_mem_wr_en = 1'b1; inst_mem_wr_data = 8'h11;
    step();
    inst_mem_wr_en = 1'b0;
    step();
    chk("instr_hold", 32'(instr), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/datapath_stack.md
Name: datapath_stack

Overview:
- Parametrised next-generation CPU datapath for the AXI-Stream packet CPU.
- Holds A, X, PC, the scratch register file, the programmable immediate and jump-offset tables, instruction memory and a registered ALU.
- Adds what the previous datapath lacked: configurable data width, register and table depth, and a hardware call/return stack with sticky overflow/underflow flags.

Parameters:
- DATA_WIDTH, 32, width of A, X, B, immediates, scratch regs and stream data
- CODE_ADDR_WIDTH, 10, PC and instruction-memory address width
- INST_WIDTH, 8, instruction word width
- UTIL_ADDR_WIDTH, 4, address width of scratch regs, imm table and jmp table (depth 2^UTIL_ADDR_WIDTH each)
- JMP_WIDTH, 8, stored jump-offset width (signed two's complement)
- STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_rd_en  in  1  instruction memory read enable
- instr  out  INST_WIDTH  registered instruction at PC
- A_sel / X_sel  in  3  source selects for A / X
- A_en / X_en  in  1  load enables for A / X
- PC_sel  in  3  PC next-value select
- PC_en  in  1  PC update enable
- B_sel  in  1  0 = X, 1 = imm
- ALU_sel  in  4  ALU operation
- ALU_en  in  1  capture ALU result
- eq, gt, ge, set  out  1  comparison flags
- din_TDATA  in  DATA_WIDTH  stream input data
- din_TLAST  in  1  stream input last
- dout_TDATA  out  DATA_WIDTH  stream output data (A if regfile_sel=0, else X)
- dout_TLAST  out  1  equals last_out
- last_en  in  1  capture din_TLAST
- last_out  in  1  controller's output last
- last  out  1  registered din_TLAST
- utility_addr  in  UTIL_ADDR_WIDTH  reg / imm / jmp index
- regfile_sel  in  1  0 = write A, 1 = write X
- regfile_wr_en  in  1  scratch write
- imm_sel_en / jmp_off_sel_en  in  1  latch utility_addr into the imm / jmp select register
- imm_wr_en, imm_wr_addr, imm_wr_data  in  1 / UTIL_ADDR_WIDTH / DATA_WIDTH  imm table write port
- jmp_off_wr_en, jmp_off_wr_addr, jmp_off_wr_data  in  1 / UTIL_ADDR_WIDTH / JMP_WIDTH  jmp table write port
- inst_mem_wr_en, inst_mem_wr_addr, inst_mem_wr_data  in  1 / CODE_ADDR_WIDTH / INST_WIDTH  program write port
- jmp_correction  in  CODE_ADDR_WIDTH  pipeline offset subtracted on jump, call and return-address push
- branch_mispredict  in  1  clears ALU result register
- stack_ovf, stack_unf  out  1  sticky stack error flags
- stack_level  out  clog2(STACK_DEPTH+1)  current occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Cleared on reset: A, X, PC, ALU result, last, imm_sel_r, jmp_sel_r, stack pointer, stack_ovf, stack_unf, stack_level, instr.
  - Not reset: tables, scratch regs, instruction memory.
- A_sel codes: 0 imm, 1 scratch[utility_addr], 2 ALU result, 3 din_TDATA, 4 X. Codes 5-7 hold A.
- X_sel codes: 0 imm, 1 scratch, 3 din_TDATA, 4 A. Codes 2 and 5-7 hold X.
- Scratch regs: asynchronous read, synchronous write.
- imm and jmp_off are asynchronous reads of their tables at the latched select registers (one cycle after the sel_en pulse).
- jmp_off is sign-extended or truncated to CODE_ADDR_WIDTH.
- instr: synchronous read of mem[PC] when inst_rd_en; holds otherwise. Write port is independent.
  - Read and write to the same address in the same cycle return the old data.
- ALU: combinational op on A and B; result registered when ALU_en (latency 1); held otherwise; cleared by branch_mispredict.
  - ALU_sel 0 add, 1 sub, 2 and, 3 or, 4 xor.
  - ALU_sel 5 shl, 6 logical shr; shift amount is B[clog2(DATA_WIDTH)-1:0].
  - ALU_sel 7 negate A. Codes 8-15 produce 0.
  - All arithmetic is modulo 2^DATA_WIDTH.
- Flags: combinational, unsigned compare of A vs B. eq = A==B, gt = A>B, ge = A>=B, set = |(A&B).
- PC_sel codes (apply only when PC_en):
  - 0 hold; 1 PC+1; 2 PC+jmp_off-jmp_correction; all modulo 2^CODE_ADDR_WIDTH.
  - 3 CALL: push PC+1-jmp_correction, then PC <= PC+jmp_off-jmp_correction.
  - 4 RET: PC <= top entry, then pop.
  - 5-7 hold.
- Stack boundaries:
  - CALL while full: push dropped, stack_ovf<=1, jump still taken.
  - RET while empty: PC<=0, stack_unf<=1, level stays 0.
  - Flags clear only on rst.
- rst while a CALL or RET is presented: rst wins, stack empty.
- last: captures din_TLAST when last_en.

Test Plan:
- Reset: drive rst 1 cycle with all enables high -> PC=0, A=0, X=0, stack_level=0, flags 0.
- Imm/ALU: write imm[3]=0x0000_0005; latch sel 3; A<=imm; X<=imm; ALU add with B=X, ALU_en, A<=ALU -> A=0xA, eq=0, gt=1, ge=1.
- Negative jump: jmp[2]=0xFC, correction 1, PC=20, PC_sel=2 -> PC=15. With CODE_ADDR_WIDTH=10 check wrap: PC=2, offset 0xFC -> PC=0x3FD.
- Nested calls, STACK_DEPTH=4: five CALLs, then four RETs -> stack_ovf=1 after the fifth call; returns pop in LIFO order. Then one extra RET -> PC=0, stack_unf=1.
- Mispredict: ALU_en captures 7, then branch_mispredict -> ALU result 0 the next cycle. Also check instruction-memory read-during-write at the same address returns old data.
